// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing a multi-cycle datapath with memory wait and timeout handling
module multicycle_control_unit #(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned ALUOP_W = 3,
    parameter logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0),
    parameter logic [OPCODE_W-1:0] OP_LW = OPCODE_W'(1),
    parameter logic [OPCODE_W-1:0] OP_SW = OPCODE_W'(8),
    parameter logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(9),
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                branch,
    output logic                regdst,
    output logic                alusrc,
    output logic                regwrite,
    output logic                memread,
    output logic                memreg,
    output logic                memwrite,
    output logic [ALUOP_W-1:0]  aluop,
    output logic                pc_write,
    output logic                ir_write,
    output logic                illegal_op,
    output logic                fault,
    output logic [3:0]          state_o
);
    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                           S_R_WB = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_LD_WB = 4'd7,
                           S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_ILLEGAL = 4'd10, S_FAULT = 4'd11;
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 2);

    logic [3:0]          state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wait_st, timeout;

    assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout = (MEM_TIMEOUT > 0) && (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) && !mem_ready;
    assign state_o = state_q;

    // state, latched opcode and wait counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state; counter restarts whenever the state changes, so each wait state entry begins at zero
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        if (en) begin
            case (state_q)
                S_IDLE:     state_d = S_FETCH;
                S_FETCH:    state_d = mem_ready ? S_DECODE : timeout ? S_FAULT : S_FETCH;
                S_DECODE: begin
                    op_d    = opcode;
                    state_d = (opcode == OP_RTYPE) ? S_EXEC_R :
                              (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                              (opcode == OP_BEQ) ? S_BRANCH : S_ILLEGAL;
                end
                S_EXEC_R:   state_d = S_R_WB;
                S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   state_d = mem_ready ? S_LD_WB : timeout ? S_FAULT : S_MEM_RD;
                S_MEM_WR:   state_d = mem_ready ? S_FETCH : timeout ? S_FAULT : S_MEM_WR;
                S_R_WB, S_LD_WB, S_BRANCH, S_ILLEGAL: state_d = S_FETCH;
                S_FAULT:    state_d = S_FAULT;
                default:    state_d = S_IDLE;
            endcase
        end
        cnt_d = (state_d != state_q) ? '0 : (en && wait_st && !mem_ready) ? cnt_q + 1'b1 : cnt_q;
    end

    // Moore outputs decoded from state; only the fetch strobes look at inputs
    always_comb begin
        {branch, regdst, alusrc, regwrite, memread, memreg, memwrite, illegal_op, fault} = '0;
        aluop = '0;
        case (state_q)
            S_FETCH:    memread = 1'b1;
            S_EXEC_R:   begin regdst = 1'b1; aluop = ALUOP_W'(4); end
            S_R_WB:     begin regdst = 1'b1; regwrite = 1'b1; aluop = ALUOP_W'(4); end
            S_MEM_ADDR: begin alusrc = 1'b1; aluop = ALUOP_W'(2); end
            S_MEM_RD:   begin memread = 1'b1; alusrc = 1'b1; aluop = ALUOP_W'(2); end
            S_LD_WB:    begin regwrite = 1'b1; memreg = 1'b1; end
            S_MEM_WR:   begin memwrite = 1'b1; alusrc = 1'b1; aluop = ALUOP_W'(2); end
            S_BRANCH:   begin branch = 1'b1; aluop = ALUOP_W'(1); end
            S_ILLEGAL:  illegal_op = 1'b1;
            S_FAULT:    fault = 1'b1;
            default:    ;
        endcase
    end

    assign pc_write = (state_q == S_FETCH) && mem_ready && en;
    assign ir_write = pc_write;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: table-driven and directed checks of the multicycle control FSM
module tb_multicycle_control_unit;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, mem_ready = 1'b0;
    logic [3:0] opcode = 4'd0;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    // output bundle bit order: branch regdst alusrc regwrite memread memreg memwrite aluop[2:0] pc_write ir_write illegal_op fault
    localparam logic [13:0] O_NONE = 14'h0000, O_FETCH = 14'h0200, O_FETCH_GO = 14'h020C,
                            O_EXEC = 14'h1040, O_RWB = 14'h1440, O_MADDR = 14'h0820,
                            O_MRD = 14'h0A20, O_LDWB = 14'h0500, O_MWR = 14'h08A0,
                            O_BR = 14'h2010, O_ILL = 14'h0002, O_FAULT = 14'h0001;

    logic d_br, d_rd, d_as, d_rw, d_mr, d_mg, d_mw, d_pw, d_iw, d_il, d_ft;
    logic t_br, t_rd, t_as, t_rw, t_mr, t_mg, t_mw, t_pw, t_iw, t_il, t_ft;
    logic [2:0] d_alu, t_alu;
    logic [3:0] d_st, t_st;
    logic [17:0] d_all, t_all;

    assign d_all = {d_st, d_br, d_rd, d_as, d_rw, d_mr, d_mg, d_mw, d_alu, d_pw, d_iw, d_il, d_ft};
    assign t_all = {t_st, t_br, t_rd, t_as, t_rw, t_mr, t_mg, t_mw, t_alu, t_pw, t_iw, t_il, t_ft};

    multicycle_control_unit d (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .mem_ready(mem_ready),
        .branch(d_br), .regdst(d_rd), .alusrc(d_as), .regwrite(d_rw), .memread(d_mr),
        .memreg(d_mg), .memwrite(d_mw), .aluop(d_alu), .pc_write(d_pw), .ir_write(d_iw),
        .illegal_op(d_il), .fault(d_ft), .state_o(d_st)
    );

    multicycle_control_unit #(.MEM_TIMEOUT(4)) t (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .mem_ready(mem_ready),
        .branch(t_br), .regdst(t_rd), .alusrc(t_as), .regwrite(t_rw), .memread(t_mr),
        .memreg(t_mg), .memwrite(t_mw), .aluop(t_alu), .pc_write(t_pw), .ir_write(t_iw),
        .illegal_op(t_il), .fault(t_ft), .state_o(t_st)
    );

    typedef struct {
        logic        en;
        logic        rdy;
        logic [3:0]  op;
        logic [3:0]  st;
        logic [13:0] o;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic e, input logic r, input logic [3:0] op, input logic [3:0] st, input logic [13:0] o);
        vecs.push_back('{e, r, op, st, o});
    endtask

    task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h", nm, act[17:14], act[13:0], exp[17:14], exp[13:0]);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [3:0] op, input logic rdy);
        rst_n = r; en = e; opcode = op; mem_ready = rdy;
        #1;
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] op, input logic rdy);
        drive(r, e, op, rdy);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        add(1, 1, 0, 0, O_NONE);
        add(1, 1, 0, 1, O_FETCH_GO);
        add(1, 1, 0, 2, O_NONE);
        add(1, 1, 0, 3, O_EXEC);
        add(1, 1, 0, 4, O_RWB);
        add(1, 1, 0, 1, O_FETCH_GO);
        add(1, 1, 1, 2, O_NONE);
        add(1, 1, 1, 5, O_MADDR);
        add(1, 0, 1, 6, O_MRD);
        add(1, 0, 1, 6, O_MRD);
        add(1, 0, 1, 6, O_MRD);
        add(1, 1, 1, 6, O_MRD);
        add(1, 1, 1, 7, O_LDWB);
        add(1, 1, 8, 1, O_FETCH_GO);
        add(1, 1, 8, 2, O_NONE);
        add(1, 1, 8, 5, O_MADDR);
        add(1, 1, 8, 8, O_MWR);
        add(1, 1, 9, 1, O_FETCH_GO);
        add(1, 1, 9, 2, O_NONE);
        add(1, 1, 9, 9, O_BR);
        add(1, 1, 5, 1, O_FETCH_GO);
        add(1, 1, 5, 2, O_NONE);
        add(1, 1, 5, 10, O_ILL);
        add(1, 1, 1, 1, O_FETCH_GO);
        add(1, 1, 1, 2, O_NONE);
        add(1, 1, 0, 5, O_MADDR);
        add(1, 0, 0, 6, O_MRD);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 6, O_MRD);
        add(1, 0, 0, 6, O_MRD);
        add(1, 1, 0, 6, O_MRD);
        add(1, 1, 0, 7, O_LDWB);
        add(0, 1, 8, 1, O_FETCH);
        add(1, 1, 8, 1, O_FETCH_GO);
        add(1, 1, 8, 2, O_NONE);
        add(1, 1, 8, 5, O_MADDR);
        add(1, 0, 8, 8, O_MWR);

        step(0, 1, 0, 1);
        drive(1, 0, 0, 0);
        chk("reset_d", d_all, {4'd0, O_NONE});
        chk("reset_t", t_all, {4'd0, O_NONE});

        foreach (vecs[i]) begin
            drive(1, vecs[i].en, vecs[i].op, vecs[i].rdy);
            chk($sformatf("vec%0d_d", i), d_all, {vecs[i].st, vecs[i].o});
            chk($sformatf("vec%0d_t", i), t_all, {vecs[i].st, vecs[i].o});
            @(negedge clk);
        end

        step(0, 1, 0, 1);
        drive(1, 0, 0, 1);
        chk("rst_mid_memwr_d", d_all, {4'd0, O_NONE});
        chk("rst_mid_memwr_t", t_all, {4'd0, O_NONE});

        step(1, 1, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        chk("fetch_before_timeout_t", t_all, {4'd1, O_FETCH});
        @(negedge clk);
        drive(1, 1, 0, 1);
        chk("timeout_fault_t", t_all, {4'd11, O_FAULT});
        chk("no_timeout_d", d_all, {4'd1, O_FETCH_GO});
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        drive(1, 1, 0, 1);
        chk("fault_sticky_t", t_all, {4'd11, O_FAULT});
        step(0, 1, 0, 1);
        drive(1, 0, 0, 0);
        chk("rst_from_fault_t", t_all, {4'd0, O_NONE});

        step(1, 1, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        drive(1, 1, 0, 1);
        chk("ready_on_timeout_cycle_t", t_all, {4'd1, O_FETCH_GO});
        @(negedge clk);
        drive(1, 0, 0, 1);
        chk("ready_wins_t", t_all, {4'd2, O_NONE});

        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        repeat (15) step(1, 1, 0, 0);
        drive(1, 1, 0, 0);
        chk("default_15_waits_d", d_all, {4'd1, O_FETCH});
        @(negedge clk);
        drive(1, 1, 0, 0);
        chk("default_timeout_d", d_all, {4'd11, O_FAULT});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OPCODE_W, default 4, opcode width.
REQ-002 SHALL have parameter ALUOP_W, default 3, aluop width.
REQ-003 SHALL have parameters OP_RTYPE=0, OP_LW=1, OP_SW=8, OP_BEQ=9, opcode encodings.
REQ-004 SHALL have parameter MEM_TIMEOUT, default 16, max wait cycles per memory access; 0 disables timeout.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 SHALL have ports, in order:
  clk  in  1  clock, rising edge
  rst_n  in  1  synchronous active-low reset
  en  in  1  advance enable; 0 freezes FSM
  opcode  in  OPCODE_W  instruction opcode, valid in DECODE
  mem_ready  in  1  memory access completes this cycle
  branch, regdst, alusrc, regwrite, memread, memreg, memwrite  out  1 each  datapath controls
  aluop  out  ALUOP_W  ALU operation
  pc_write  out  1  PC update strobe
  ir_write  out  1  instruction register load strobe
  illegal_op  out  1  undefined opcode decoded
  fault  out  1  memory timeout, sticky
  state_o  out  4  current state encoding, debug

Function
REQ-007 SHALL be a Moore FSM; all outputs except pc_write/ir_write are decoded from the state register only.
REQ-008 States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, R_WB=4, MEM_ADDR=5, MEM_RD=6, LD_WB=7, MEM_WR=8, BRANCH=9, ILLEGAL=10, FAULT=11.
REQ-009 Outputs not listed for a state SHALL be 0.
REQ-010 IDLE: all outputs 0; -> FETCH when en=1.
REQ-011 FETCH: memread=1; ir_write=pc_write=(mem_ready & en); -> DECODE when mem_ready & en.
REQ-012 DECODE: latch opcode into op_q; OP_RTYPE -> EXEC_R, OP_LW or OP_SW -> MEM_ADDR, OP_BEQ -> BRANCH, any other -> ILLEGAL.
REQ-013 EXEC_R: regdst=1, aluop=4 -> R_WB; R_WB: regdst=1, regwrite=1, aluop=4 -> FETCH.
REQ-014 MEM_ADDR: alusrc=1, aluop=2; -> MEM_RD if op_q=OP_LW, else MEM_WR.
REQ-015 MEM_RD: memread=1, alusrc=1, aluop=2; -> LD_WB when mem_ready & en. LD_WB: regwrite=1, memreg=1 -> FETCH.
REQ-016 MEM_WR: memwrite=1, alusrc=1, aluop=2; -> FETCH when mem_ready & en.
REQ-017 BRANCH: branch=1, aluop=1 -> FETCH.
REQ-018 ILLEGAL: illegal_op=1 for exactly one cycle -> FETCH.
REQ-019 FAULT: fault=1, all other outputs 0; no exit except reset.
REQ-020 Non-wait states advance one state per cycle when en=1; en=0 holds state, op_q and timeout counter.
REQ-021 Timeout counter: cleared on entry to FETCH/MEM_RD/MEM_WR; increments each en=1 cycle in those states with mem_ready=0.
REQ-022 When MEM_TIMEOUT>0 and counter reaches MEM_TIMEOUT-1 with mem_ready=0 and en=1, next state SHALL be FAULT.
REQ-023 mem_ready=1 on the timeout cycle SHALL win; normal transition taken.
REQ-024 Instruction latency with zero-wait memory: R-type 4 cycles, LW 5, SW 4, BEQ 3, illegal 3 (FETCH to next FETCH).

Reset
REQ-025 rst_n=0 at rising clk SHALL force state IDLE, op_q=0, counter=0; all outputs 0 the following cycle, including mid-wait and from FAULT.
REQ-026 Reset SHALL take priority over en and mem_ready.

Verification
REQ-027 Reset, en=1, mem_ready=1, opcode=0 -> states 0,1,2,3,4,1; R_WB shows regdst=1, regwrite=1, aluop=4.
REQ-028 opcode=1, mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then LD_WB with memreg=1, regwrite=1.
REQ-029 opcode=8 -> MEM_WR memwrite=1, aluop=2, alusrc=1; opcode=9 -> BRANCH branch=1, aluop=1.
REQ-030 opcode=5 -> ILLEGAL, illegal_op high one cycle, then FETCH.
REQ-031 MEM_TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 4 cycles, fault sticky; mem_ready=1 on 4th cycle -> DECODE instead.
REQ-032 en=0 mid-MEM_RD for 5 cycles -> state held, no timeout; rst_n=0 mid-MEM_WR -> IDLE, all outputs 0.
